evm_ballot_ctrl: RTL and testbench

EVM_BALLOT_CTRL -- requirements
Module: evm_ballot_ctrl

---
 rtl/evm_pkg.sv | 38 +++
 rtl/evm_debounce.sv | 55 +++++
 rtl/evm_ballot_ctrl.sv | 121 ++++++++++++
 tb/tb_evm_ballot_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// ============================================================================
// Module : evm_pkg
// Brief  : Shared state encoding, party count and selector decode helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package evm_pkg;

    localparam int N_PARTIES = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ARM = 3'd1,
        ST_ARMED    = 3'd2,
        ST_CAST     = 3'd3,
        ST_LOCKED   = 3'd4,
        ST_FULL     = 3'd5
    } state_e;

    function automatic logic is_onehot(input logic [N_PARTIES-1:0] sel);
        logic [N_PARTIES-1:0] dec;
        dec = sel - {{(N_PARTIES-1){1'b0}}, 1'b1};
        return (sel != '0) && ((sel & dec) == '0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [N_PARTIES-1:0] sel);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < N_PARTIES; i++) begin
            if (sel[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/evm_debounce.sv
// ============================================================================
// Module : evm_debounce
// Brief  : 2-flop synchroniser plus level debouncer with rising-edge pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module evm_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive samples that disagree with the accepted level
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

`default_nettype wire

// File: rtl/evm_ballot_ctrl.sv
// ============================================================================
// Module : evm_ballot_ctrl
// Brief  : Ballot unit control FSM: arm, cast, timeout and session vote count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int MAX_VOTES    = 127
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 session_open,
    input  logic                 arm,
    input  logic [N_PARTIES-1:0] voter_switch,
    input  logic                 push_button,
    output logic                 vote_strobe,
    output logic [1:0]           vote_party,
    output logic                 ballot_ready,
    output logic                 err_invalid,
    output logic                 err_timeout,
    output logic [6:0]           total_votes,
    output logic [2:0]           state
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic          btn_level;
    logic          btn_rise;
    state_e        state_q;
    logic [TW-1:0] tmo_q;
    logic          vote_strobe_q;
    logic [1:0]    vote_party_q;
    logic          ballot_ready_q;
    logic          err_invalid_q;
    logic          err_timeout_q;
    logic [6:0]    total_q;

    evm_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   (push_button),
        .level_o (btn_level),
        .rise_o  (btn_rise)
    );

    // The strobe already left in CAST, so the vote is counted even if polling closes then
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tmo_q          <= '0;
            vote_strobe_q  <= 1'b0;
            vote_party_q   <= 2'd0;
            ballot_ready_q <= 1'b0;
            err_invalid_q  <= 1'b0;
            err_timeout_q  <= 1'b0;
            total_q        <= 7'd0;
        end else begin
            vote_strobe_q  <= 1'b0;
            err_invalid_q  <= 1'b0;
            err_timeout_q  <= 1'b0;
            ballot_ready_q <= 1'b0;
            if (state_q == ST_CAST) begin
                total_q <= total_q + 7'd1;
                if ((total_q + 7'd1) == 7'(MAX_VOTES))
                    state_q <= ST_FULL;
                else
                    state_q <= session_open ? ST_LOCKED : ST_IDLE;
            end else if (state_q != ST_FULL && !session_open) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_WAIT_ARM;
                    ST_WAIT_ARM: begin
                        if (arm) begin
                            state_q        <= ST_ARMED;
                            tmo_q          <= '0;
                            ballot_ready_q <= 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (btn_rise && is_onehot(voter_switch)) begin
                            state_q       <= ST_CAST;
                            vote_party_q  <= onehot_idx(voter_switch);
                            vote_strobe_q <= 1'b1;
                        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                            state_q       <= ST_WAIT_ARM;
                            err_timeout_q <= 1'b1;
                        end else begin
                            ballot_ready_q <= 1'b1;
                            err_invalid_q  <= btn_rise;
                            tmo_q          <= tmo_q + TW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (!btn_level) state_q <= ST_WAIT_ARM;
                    end
                    ST_FULL: state_q <= ST_FULL;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign vote_strobe  = vote_strobe_q;
    assign vote_party   = vote_party_q;
    assign ballot_ready = ballot_ready_q;
    assign err_invalid  = err_invalid_q;
    assign err_timeout  = err_timeout_q;
    assign total_votes  = total_q;
    assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_evm_ballot_ctrl.sv
// ============================================================================
// Module : tb_evm_ballot_ctrl
// Brief  : Directed self-checking bench for evm_ballot_ctrl (MAX_VOTES=3).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_evm_ballot_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       session_open;
    logic       arm;
    logic [3:0] voter_switch;
    logic       push_button;
    logic       vote_strobe;
    logic [1:0] vote_party;
    logic       ballot_ready;
    logic       err_invalid;
    logic       err_timeout;
    logic [6:0] total_votes;
    logic [2:0] dut_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int str_cnt = 0;
    int inv_cnt = 0;
    int tmo_cnt = 0;
    int strobe_cyc = 0;
    int last_party = -1;
    int p_cyc;
    int s0;
    int i0;
    int t0;

    evm_ballot_ctrl #(
        .DEBOUNCE_CYC (16),
        .TIMEOUT_CYC  (1000),
        .MAX_VOTES    (3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .session_open (session_open),
        .arm          (arm),
        .voter_switch (voter_switch),
        .push_button  (push_button),
        .vote_strobe  (vote_strobe),
        .vote_party   (vote_party),
        .ballot_ready (ballot_ready),
        .err_invalid  (err_invalid),
        .err_timeout  (err_timeout),
        .total_votes  (total_votes),
        .state        (dut_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vote_strobe) begin
            str_cnt    = str_cnt + 1;
            last_party = int'(vote_party);
            strobe_cyc = cyc;
        end
        if (err_invalid) inv_cnt = inv_cnt + 1;
        if (err_timeout) tmo_cnt = tmo_cnt + 1;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        session_open = 1'b0;
        arm          = 1'b0;
        push_button  = 1'b0;
        voter_switch = 4'b0000;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic vote(input logic [3:0] sw);
        arm_pulse();
        voter_switch = sw;
        push_button  = 1'b1;
        repeat (20) tick();
        push_button = 1'b0;
        repeat (30) tick();
    endtask

    initial begin
        reset_n = 1'b0; session_open = 1'b0; arm = 1'b0;
        voter_switch = 4'b0000; push_button = 1'b0;
        repeat (3) tick();
        check_val("rst_state", int'(dut_state), 0);
        check_val("rst_total", int'(total_votes), 0);
        check_val("rst_ready", int'(ballot_ready), 0);
        check_val("rst_strobe", int'(vote_strobe), 0);
        check_val("rst_party", int'(vote_party), 0);
        reset_n = 1'b1;

        // Basic vote for party 1 with exact press-to-strobe latency
        session_open = 1'b1;
        tick();
        check_val("open_wait_arm", int'(dut_state), 1);
        arm_pulse();
        check_val("armed_state", int'(dut_state), 2);
        check_val("armed_ready", int'(ballot_ready), 1);
        voter_switch = 4'b0010;
        s0 = str_cnt;
        push_button = 1'b1;
        p_cyc = cyc;
        repeat (20) tick();
        check_val("a_strobes", str_cnt - s0, 1);
        check_val("a_latency", strobe_cyc - p_cyc, 19);
        check_val("a_party", last_party, 1);
        check_val("a_locked", int'(dut_state), 4);
        check_val("a_total", int'(total_votes), 1);
        push_button = 1'b0;
        repeat (30) tick();
        check_val("a_unlock", int'(dut_state), 1);

        // Invalid selection, then a valid one for party 3
        arm_pulse();
        voter_switch = 4'b0110;
        s0 = str_cnt; i0 = inv_cnt;
        push_button = 1'b1;
        repeat (20) tick();
        push_button = 1'b0;
        repeat (25) tick();
        check_val("b_invalid", inv_cnt - i0, 1);
        check_val("b_no_strobe", str_cnt - s0, 0);
        check_val("b_ready", int'(ballot_ready), 1);
        check_val("b_still_armed", int'(dut_state), 2);
        voter_switch = 4'b1000;
        push_button = 1'b1;
        repeat (20) tick();
        push_button = 1'b0;
        check_val("b_strobe", str_cnt - s0, 1);
        check_val("b_party", last_party, 3);
        repeat (30) tick();
        check_val("b_total", int'(total_votes), 2);
        check_val("b_wait_arm", int'(dut_state), 1);

        // Armed ballot expires after exactly 1000 cycles
        do_reset();
        session_open = 1'b1;
        tick();
        arm_pulse();
        t0 = tmo_cnt;
        repeat (999) tick();
        check_val("c_armed_999", int'(dut_state), 2);
        tick();
        check_val("c_wait_arm", int'(dut_state), 1);
        check_val("c_err_tmo", int'(err_timeout), 1);
        check_val("c_ready_off", int'(ballot_ready), 0);
        tick();
        check_val("c_err_tmo_pulse", int'(err_timeout), 0);
        check_val("c_tmo_count", tmo_cnt - t0, 1);
        check_val("c_total", int'(total_votes), 0);

        // Short glitches rejected; a long hold gives a single vote
        arm_pulse();
        voter_switch = 4'b0001;
        s0 = str_cnt;
        for (int g = 0; g < 3; g++) begin
            push_button = 1'b1;
            repeat (10) tick();
            push_button = 1'b0;
            repeat (10) tick();
        end
        check_val("d_glitch_strobe", str_cnt - s0, 0);
        check_val("d_glitch_armed", int'(dut_state), 2);
        push_button = 1'b1;
        repeat (40) tick();
        check_val("d_one_strobe", str_cnt - s0, 1);
        check_val("d_party", last_party, 0);
        check_val("d_held_locked", int'(dut_state), 4);
        push_button = 1'b0;
        repeat (30) tick();
        check_val("d_wait_arm", int'(dut_state), 1);
        push_button = 1'b1;
        repeat (40) tick();
        push_button = 1'b0;
        repeat (30) tick();
        check_val("d_no_rearm_vote", str_cnt - s0, 1);
        check_val("d_total", int'(total_votes), 1);

        // Capacity reached: FULL ignores everything until reset
        vote(4'b0100);
        check_val("e_total2", int'(total_votes), 2);
        vote(4'b1000);
        check_val("e_full", int'(dut_state), 5);
        check_val("e_total3", int'(total_votes), 3);
        s0 = str_cnt;
        arm_pulse();
        push_button = 1'b1;
        repeat (40) tick();
        push_button = 1'b0;
        repeat (30) tick();
        check_val("e_full_no_strobe", str_cnt - s0, 0);
        check_val("e_full_hold", int'(dut_state), 5);
        check_val("e_full_ready", int'(ballot_ready), 0);
        session_open = 1'b0;
        repeat (2) tick();
        check_val("e_full_close", int'(dut_state), 5);
        reset_n = 1'b0;
        tick();
        check_val("e_rst_state", int'(dut_state), 0);
        check_val("e_rst_total", int'(total_votes), 0);
        reset_n = 1'b1;

        // Session closes on the same cycle the press is detected
        session_open = 1'b1;
        tick();
        arm_pulse();
        voter_switch = 4'b0100;
        s0 = str_cnt;
        push_button = 1'b1;
        repeat (18) tick();
        session_open = 1'b0;
        tick();
        check_val("f_idle", int'(dut_state), 0);
        check_val("f_ready_off", int'(ballot_ready), 0);
        repeat (12) tick();
        push_button = 1'b0;
        repeat (20) tick();
        check_val("f_no_strobe", str_cnt - s0, 0);
        check_val("f_total", int'(total_votes), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
